// File: rtl/fduart_monitor_pkg.sv
// Shared definitions for the fduart debug monitor: state encoding, frame
// byte codes and the fduart status bit positions.
package fduart_monitor_pkg;

    typedef enum logic [3:0] {
        ST_HUNT = 4'd0,
        ST_CMD  = 4'd1,
        ST_AH   = 4'd2,
        ST_AL   = 4'd3,
        ST_DH   = 4'd4,
        ST_DL   = 4'd5,
        ST_BUS  = 4'd6,
        ST_TX0  = 4'd7,
        ST_TX1  = 4'd8,
        ST_TX2  = 4'd9
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] ACK_BYTE  = 8'h4B;
    localparam logic [7:0] NAK_BYTE  = 8'h3F;

    // Positions of the fduart status_out flags (mirrors target_program_defines.v).
    localparam int ARX_FIFO_EMPTY_BIT = 0;
    localparam int ATX_FIFO_FULL_BIT  = 1;

    function automatic logic is_rx_state(input state_t s);
        return (s == ST_HUNT) || (s == ST_CMD) || (s == ST_AH) ||
               (s == ST_AL) || (s == ST_DH) || (s == ST_DL);
    endfunction

    // Mid-frame states in which the inter-byte timeout runs.
    function automatic logic is_timed_state(input state_t s);
        return is_rx_state(s) && (s != ST_HUNT);
    endfunction

    function automatic logic is_tx_state(input state_t s);
        return (s == ST_TX0) || (s == ST_TX1) || (s == ST_TX2);
    endfunction

endpackage

// File: rtl/fduart_monitor_timer.sv
// Inter-byte timeout counter: counts while run is high, restarts on clear,
// flags expired in the cycle the count reaches LIMIT.
module fduart_monitor_timer #(
    parameter logic [31:0] LIMIT = 32'd50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [31:0] LAST = (LIMIT == 32'd0) ? 32'd0 : LIMIT - 32'd1;

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (clear || !run) begin
            count <= 32'd0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/fduart_monitor.sv
// Serial debug responder: parses read/write frames from the fduart RX FIFO,
// performs one 16-bit memory access and pushes a reply frame into the TX FIFO.
module fduart_monitor
    import fduart_monitor_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  RESP_BYTE      = 8'h5A
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic [15:0] status_in,
    input  logic [15:0] arx_data_in,
    output logic        arx_reg_read,
    output logic [15:0] atx_data_out,
    output logic        atx_reg_load,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic [3:0]  fsm_state
);

    // Handshakes: a byte moves when the FIFO flag allows it and gap is low;
    // the single-cycle pop/push pulse sets gap so the FIFO flags settle first.
    // mem_req rises on entry to BUS and falls on the edge that samples mem_ack.

    state_t      state, state_nxt;
    logic        gap, gap_nxt;
    logic [7:0]  cmd, cmd_nxt;
    logic [15:0] rdata, rdata_nxt;
    logic [15:0] addr_nxt, wdata_nxt, tx_nxt;
    logic        pop_nxt, push_nxt, req_nxt, we_nxt;
    logic        rx_ok, tx_ok, expired;
    logic [7:0]  rx_byte;
    logic        unused_inputs;

    assign unused_inputs = ^{arx_data_in[15:8], status_in};

    assign rx_byte = arx_data_in[7:0];
    assign rx_ok   = is_rx_state(state) && !gap && !status_in[ARX_FIFO_EMPTY_BIT];
    assign tx_ok   = is_tx_state(state) && !gap && !status_in[ATX_FIFO_FULL_BIT];

    fduart_monitor_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (sysclk),
        .rst_n   (sysreset_n),
        .clear   (rx_ok),
        .run     (is_timed_state(state)),
        .expired (expired)
    );

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state        <= ST_HUNT;
            gap          <= 1'b0;
            cmd          <= 8'h00;
            rdata        <= 16'h0000;
            arx_reg_read <= 1'b0;
            atx_reg_load <= 1'b0;
            atx_data_out <= 16'h0000;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
            mem_we       <= 1'b0;
            mem_req      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            gap          <= gap_nxt;
            cmd          <= cmd_nxt;
            rdata        <= rdata_nxt;
            arx_reg_read <= pop_nxt;
            atx_reg_load <= push_nxt;
            atx_data_out <= tx_nxt;
            mem_addr     <= addr_nxt;
            mem_wdata    <= wdata_nxt;
            mem_we       <= we_nxt;
            mem_req      <= req_nxt;
            busy         <= (state_nxt != ST_HUNT);
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        rdata_nxt = rdata;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        tx_nxt    = atx_data_out;
        pop_nxt   = 1'b0;
        push_nxt  = 1'b0;

        case (state)
            ST_HUNT: begin
                if (rx_ok) begin
                    pop_nxt = 1'b1;
                    if (rx_byte == SYNC_BYTE) state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_ok) begin
                    pop_nxt = 1'b1;
                    cmd_nxt = rx_byte;
                    // Anything but R/W (including a second SYNC) earns a NAK.
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) state_nxt = ST_AH;
                    else                                             state_nxt = ST_TX0;
                end else if (expired) begin
                    state_nxt = ST_HUNT;
                end
            end
            ST_AH: begin
                if (rx_ok) begin
                    pop_nxt   = 1'b1;
                    addr_nxt  = {rx_byte, mem_addr[7:0]};
                    state_nxt = ST_AL;
                end else if (expired) begin
                    state_nxt = ST_HUNT;
                end
            end
            ST_AL: begin
                if (rx_ok) begin
                    pop_nxt   = 1'b1;
                    addr_nxt  = {mem_addr[15:8], rx_byte};
                    state_nxt = (cmd == CMD_WRITE) ? ST_DH : ST_BUS;
                end else if (expired) begin
                    state_nxt = ST_HUNT;
                end
            end
            ST_DH: begin
                if (rx_ok) begin
                    pop_nxt   = 1'b1;
                    wdata_nxt = {rx_byte, mem_wdata[7:0]};
                    state_nxt = ST_DL;
                end else if (expired) begin
                    state_nxt = ST_HUNT;
                end
            end
            ST_DL: begin
                if (rx_ok) begin
                    pop_nxt   = 1'b1;
                    wdata_nxt = {mem_wdata[15:8], rx_byte};
                    state_nxt = ST_BUS;
                end else if (expired) begin
                    state_nxt = ST_HUNT;
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    if (cmd == CMD_READ) rdata_nxt = mem_rdata;
                    state_nxt = ST_TX0;
                end
            end
            ST_TX0: begin
                if (tx_ok) begin
                    push_nxt  = 1'b1;
                    tx_nxt    = {8'h00, RESP_BYTE};
                    state_nxt = ST_TX1;
                end
            end
            ST_TX1: begin
                if (tx_ok) begin
                    push_nxt = 1'b1;
                    if (cmd == CMD_READ) begin
                        tx_nxt    = {8'h00, rdata[15:8]};
                        state_nxt = ST_TX2;
                    end else begin
                        tx_nxt    = {8'h00, (cmd == CMD_WRITE) ? ACK_BYTE : NAK_BYTE};
                        state_nxt = ST_HUNT;
                    end
                end
            end
            ST_TX2: begin
                if (tx_ok) begin
                    push_nxt  = 1'b1;
                    tx_nxt    = {8'h00, rdata[7:0]};
                    state_nxt = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase

        gap_nxt = pop_nxt || push_nxt;
        req_nxt = (state_nxt == ST_BUS);
        we_nxt  = req_nxt && (cmd_nxt == CMD_WRITE);
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_fduart_monitor.sv
// Directed + randomized bench for fduart_monitor with FIFO/memory responders
// and a frame-level reference model feeding expected queues.
module tb_fduart_monitor;
    import fduart_monitor_pkg::*;

    localparam logic [31:0] TB_TIMEOUT = 32'd300;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [7:0]  RESP = 8'h5A;

    logic        sysclk = 1'b0;
    logic        sysreset_n = 1'b0;
    logic [15:0] status_in;
    logic [15:0] arx_data_in;
    logic        arx_reg_read;
    logic [15:0] atx_data_out;
    logic        atx_reg_load;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic [3:0]  fsm_state;

    fduart_monitor #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .SYNC_BYTE      (SYNC),
        .RESP_BYTE      (RESP)
    ) dut (
        .sysclk       (sysclk),
        .sysreset_n   (sysreset_n),
        .status_in    (status_in),
        .arx_data_in  (arx_data_in),
        .arx_reg_read (arx_reg_read),
        .atx_data_out (atx_data_out),
        .atx_reg_load (atx_reg_load),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_req      (mem_req),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    always #5 sysclk = ~sysclk;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [32:0] exp_acc[$];
    logic [32:0] got_acc[$];
    logic [15:0] mem_model [0:65535];
    logic [15:0] ref_mem   [0:65535];
    logic        tx_full = 1'b0;
    logic        full_at_edge = 1'b0;
    int          ack_delay = 1;
    int          req_cycles = 0;
    int          last_req_len = 0;
    int          load_while_full = 0;
    int          n_total = 0;
    int          n_pass = 0;

    // Full flag actually seen by the DUT at each edge.
    always @(posedge sysclk) full_at_edge <= status_in[ATX_FIFO_FULL_BIT];

    // FIFO and memory responders, all updated away from the active edge.
    always @(negedge sysclk) begin
        if (arx_reg_read === 1'b1 && rx_q.size() > 0) void'(rx_q.pop_front());
        if (atx_reg_load === 1'b1) begin
            got_tx.push_back(atx_data_out[7:0]);
            if (full_at_edge) load_while_full++;
        end
        if (mem_req === 1'b1) begin
            req_cycles++;
            if (ack_delay != 0 && req_cycles == ack_delay) begin
                mem_ack = 1'b1;
                last_req_len = req_cycles;
                got_acc.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0000});
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else        mem_rdata = mem_model[mem_addr];
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            req_cycles = 0;
            mem_ack = 1'b0;
        end
        status_in = 16'h0000;
        status_in[ARX_FIFO_EMPTY_BIT] = (rx_q.size() == 0);
        status_in[ATX_FIFO_FULL_BIT]  = tx_full;
        arx_data_in = (rx_q.size() > 0) ? {8'h00, rx_q[0]} : 16'h0000;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Frame-level model: scan for SYNC, decode command, emit expected traffic.
    task automatic model_bytes(input logic [7:0] b[$]);
        int i = 0;
        logic [15:0] a, d;
        while (i < b.size()) begin
            if (b[i] != SYNC || i + 1 >= b.size()) begin
                i++;
                continue;
            end
            if (b[i+1] == 8'h52 && i + 3 < b.size()) begin
                a = {b[i+2], b[i+3]};
                exp_acc.push_back({1'b0, a, 16'h0000});
                exp_tx.push_back(RESP);
                exp_tx.push_back(ref_mem[a][15:8]);
                exp_tx.push_back(ref_mem[a][7:0]);
                i += 4;
            end else if (b[i+1] == 8'h57 && i + 5 < b.size()) begin
                a = {b[i+2], b[i+3]};
                d = {b[i+4], b[i+5]};
                exp_acc.push_back({1'b1, a, d});
                ref_mem[a] = d;
                exp_tx.push_back(RESP);
                exp_tx.push_back(8'h4B);
                i += 6;
            end else begin
                exp_tx.push_back(RESP);
                exp_tx.push_back(8'h3F);
                i += 2;
            end
        end
    endtask

    task automatic send(input logic [7:0] b[$], input bit use_model);
        foreach (b[k]) rx_q.push_back(b[k]);
        if (use_model) model_bytes(b);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int stable = 0;
        int cyc = 0;
        while (stable < 3 && cyc < bound) begin
            tick(1);
            cyc++;
            if (rx_q.size() == 0 && busy === 1'b0 && mem_req === 1'b0) stable++;
            else stable = 0;
        end
        chk({tag, "_idle_in_time"}, 64'(stable >= 3), 64'd1);
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_tx_count"}, 64'(got_tx.size()), 64'(exp_tx.size()));
        for (int k = 0; k < got_tx.size() && k < exp_tx.size(); k++)
            chk($sformatf("%s_tx%0d", tag, k), 64'(got_tx[k]), 64'(exp_tx[k]));
        chk({tag, "_acc_count"}, 64'(got_acc.size()), 64'(exp_acc.size()));
        for (int k = 0; k < got_acc.size() && k < exp_acc.size(); k++)
            chk($sformatf("%s_acc%0d", tag, k), 64'(got_acc[k]), 64'(exp_acc[k]));
        got_tx.delete(); exp_tx.delete(); got_acc.delete(); exp_acc.delete();
    endtask

    initial begin
        logic [7:0] f[$];
        int cyc;
        int held;
        logic [15:0] a, d;
        logic [7:0] c;

        for (int k = 0; k < 65536; k++) begin
            mem_model[k] = 16'($urandom);
            ref_mem[k]   = mem_model[k];
        end
        mem_model[16'h0010] = 16'hCAFE;
        ref_mem[16'h0010]   = 16'hCAFE;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;

        // Reset values
        tick(4);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_rx_pop", 64'(arx_reg_read), 64'd0);
        chk("rst_tx_load", 64'(atx_reg_load), 64'd0);
        chk("rst_tx_data", 64'(atx_data_out), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_state", 64'(fsm_state), 64'(ST_HUNT));
        sysreset_n = 1'b1;
        tick(2);

        // Write frame
        ack_delay = 1;
        f = '{8'hA5, 8'h57, 8'h12, 8'h34, 8'hBE, 8'hEF};
        send(f, 1'b1);
        wait_idle("write", 200);
        check_sb("write");

        // Read frame with a 5-cycle ack
        ack_delay = 5;
        f = '{8'hA5, 8'h52, 8'h00, 8'h10};
        send(f, 1'b1);
        wait_idle("read", 200);
        chk("read_req_len", 64'(last_req_len), 64'd5);
        check_sb("read");

        // Garbage then a read
        ack_delay = 1;
        f = '{8'h00, 8'hFF, 8'h33, 8'hA5, 8'h52, 8'h12, 8'h34};
        send(f, 1'b1);
        wait_idle("garbage", 300);
        check_sb("garbage");

        // Truncated frame left to time out, then a normal write
        f = '{8'hA5, 8'h52, 8'h12};
        send(f, 1'b0);
        tick(int'(TB_TIMEOUT) + 40);
        chk("timeout_busy", 64'(busy), 64'd0);
        check_sb("timeout");
        f = '{8'hA5, 8'h57, 8'h00, 8'h44, 8'h12, 8'h21};
        send(f, 1'b1);
        wait_idle("after_timeout", 200);
        check_sb("after_timeout");

        // TX FIFO full during a read reply
        ack_delay = 2;
        f = '{8'hA5, 8'h52, 8'h12, 8'h34};
        send(f, 1'b1);
        cyc = 0;
        while (got_acc.size() == 0 && cyc < 200) begin tick(1); cyc++; end
        chk("full_ack_seen", 64'(got_acc.size()), 64'd1);
        tx_full = 1'b1;
        held = got_tx.size();
        tick(100);
        chk("full_no_push", 64'(got_tx.size()), 64'(held));
        chk("full_busy", 64'(busy), 64'd1);
        tx_full = 1'b0;
        wait_idle("full", 200);
        chk("load_while_full", 64'(load_while_full), 64'd0);
        check_sb("full");

        // Unknown command
        f = '{8'hA5, 8'h99};
        send(f, 1'b1);
        wait_idle("nak", 200);
        check_sb("nak");

        // Reset while the bus request is outstanding
        ack_delay = 0;
        f = '{8'hA5, 8'h52, 8'h55, 8'h66};
        send(f, 1'b0);
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < 200) begin tick(1); cyc++; end
        chk("bus_req_seen", 64'(mem_req), 64'd1);
        sysreset_n = 1'b0;
        tick(1);
        chk("bus_rst_req", 64'(mem_req), 64'd0);
        chk("bus_rst_state", 64'(fsm_state), 64'(ST_HUNT));
        sysreset_n = 1'b1;
        tick(2);
        check_sb("bus_rst");

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            f.delete();
            repeat ($urandom_range(0, 2)) begin
                c = 8'($urandom);
                if (c == SYNC) c = 8'h00;
                f.push_back(c);
            end
            a = 16'($urandom_range(0, 15));
            d = 16'($urandom);
            case ($urandom_range(0, 2))
                0: f = {f, SYNC, 8'h52, a[15:8], a[7:0]};
                1: f = {f, SYNC, 8'h57, a[15:8], a[7:0], d[15:8], d[7:0]};
                default: begin
                    c = 8'($urandom);
                    if (c == 8'h52 || c == 8'h57) c = 8'h00;
                    f = {f, SYNC, c};
                end
            endcase
            ack_delay = $urandom_range(1, 4);
            send(f, 1'b1);
            wait_idle($sformatf("rand%0d", n), 300);
        end
        check_sb("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
